// File: rtl/miner_pkg.sv
// Shared widths, FSM encoding and hit-vector helpers for the nonce dispatcher.
package miner_pkg;

    localparam int MIDSTATE_W = 256;
    localparam int DATA_W     = 96;
    localparam int NONCE_W    = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] cnt;
        cnt = 5'd0;
        for (int i = 0; i < 16; i++) begin
            cnt = cnt + {4'd0, v[i]};
        end
        return cnt;
    endfunction

    // Scanning downward leaves the lowest set index as the final assignment.
    function automatic logic [3:0] lowest_idx16(input logic [15:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/gn_fifo.sv
// Golden-nonce FIFO: count-based so any depth works; push on full succeeds
// only when a pop happens in the same cycle.
module gn_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_rd_idx;
    logic [AW-1:0]    r_wr_idx;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_data    = r_mem[r_rd_idx];
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_rd_idx <= '0;
            r_wr_idx <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_idx] <= i_data;
                r_wr_idx <= (r_wr_idx == AW'(DEPTH - 1)) ? '0 : r_wr_idx + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_idx <= (r_rd_idx == AW'(DEPTH - 1)) ? '0 : r_rd_idx + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/nonce_dispatch.sv
// Splits a nonce range across NUM_CORES hashing cores, realigns their hit
// flags through a delay line and queues golden nonces for the host.
module nonce_dispatch
    import miner_pkg::*;
#(
    parameter int NUM_CORES  = 4,
    parameter int LOOP_LOG2  = 0,
    parameter int PIPE_DEPTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           i_work_valid,
    output logic                           o_work_ready,
    input  logic [MIDSTATE_W-1:0]          i_work_midstate,
    input  logic [DATA_W-1:0]              i_work_data,
    input  logic [NONCE_W-1:0]             i_work_nonce_start,
    input  logic [NONCE_W-1:0]             i_work_nonce_end,
    output logic [MIDSTATE_W-1:0]          o_core_midstate,
    output logic [DATA_W-1:0]              o_core_data,
    output logic [NONCE_W*NUM_CORES-1:0]   o_core_nonce,
    output logic                           o_core_issue,
    input  logic [NUM_CORES-1:0]           i_core_hit,
    output logic                           o_gn_valid,
    input  logic                           i_gn_ready,
    output logic [NONCE_W-1:0]             o_gn_nonce,
    output logic                           o_busy,
    output logic                           o_range_done,
    output logic [15:0]                    o_dropped_cnt
);

    localparam logic [5:0] LOOP_LAST = 6'((1 << LOOP_LOG2) - 1);

    state_e                         r_state;
    state_e                         w_next_state;
    logic [NONCE_W-1:0]             r_base;
    logic [NONCE_W-1:0]             r_end;
    logic                           r_more;
    logic [5:0]                     r_loop_cnt;
    logic [15:0]                    r_drain_cnt;
    logic [PIPE_DEPTH-1:0]          r_dl_valid;
    logic [NONCE_W-1:0]             r_dl_base [PIPE_DEPTH];
    logic [MIDSTATE_W-1:0]          r_core_midstate;
    logic [DATA_W-1:0]              r_core_data;
    logic [NONCE_W*NUM_CORES-1:0]   r_core_nonce;
    logic                           r_core_issue;
    logic                           r_busy;
    logic                           r_range_done;
    logic [15:0]                    r_dropped;

    logic                           w_accept;
    logic                           w_issue_now;
    logic                           w_issue_last;
    logic                           w_last_seen;
    logic                           w_range_done_nx;
    logic [NONCE_W-1:0]             w_issue_base;
    logic [NONCE_W-1:0]             w_issue_end;
    logic [15:0]                    w_hit16;
    logic                           w_push;
    logic [NONCE_W-1:0]             w_push_nonce;
    logic [4:0]                     w_extra;
    logic                           w_pop;
    logic                           w_fifo_full;
    logic                           w_fifo_empty;
    logic [16:0]                    w_drop_sum;
    logic [15:0]                    w_drop_next;

    assign o_work_ready    = 1'b1;
    assign o_core_midstate = r_core_midstate;
    assign o_core_data     = r_core_data;
    assign o_core_nonce    = r_core_nonce;
    assign o_core_issue    = r_core_issue;
    assign o_busy          = r_busy;
    assign o_range_done    = r_range_done;
    assign o_dropped_cnt   = r_dropped;
    assign o_gn_valid      = ~w_fifo_empty;

    assign w_accept     = i_work_valid;
    assign w_last_seen  = (r_state == ST_RUN) & r_core_issue & ~r_more;
    assign w_issue_base = w_accept ? i_work_nonce_start : r_base;
    assign w_issue_end  = w_accept ? i_work_nonce_end : r_end;
    assign w_issue_now  = w_accept |
                          ((r_state == ST_RUN) & r_more & (r_loop_cnt == LOOP_LAST));
    // 33-bit compare so a range ending at 0xFFFFFFFF never wraps to zero.
    assign w_issue_last = ({1'b0, w_issue_base} + 33'(NUM_CORES - 1)) >= {1'b0, w_issue_end};
    assign w_range_done_nx = ~w_accept &
                             (((r_state == ST_DRAIN) & (r_drain_cnt == 16'd1)) |
                              ((PIPE_DEPTH == 1) & w_last_seen));

    // Next-state decode; a work load wins from any state.
    always_comb begin
        w_next_state = r_state;
        if (w_accept) begin
            w_next_state = ST_RUN;
        end else begin
            case (r_state)
                ST_IDLE:  w_next_state = ST_IDLE;
                ST_RUN:   w_next_state = w_last_seen ? ST_DRAIN : ST_RUN;
                ST_DRAIN: w_next_state = (r_drain_cnt == 16'd0) ? ST_IDLE : ST_DRAIN;
                default:  w_next_state = ST_IDLE;
            endcase
        end
    end

    // Hit qualification, FIFO push selection and saturating drop accounting.
    always_comb begin
        w_hit16      = 16'(i_core_hit);
        w_pop        = o_gn_valid & i_gn_ready;
        w_push       = 1'b0;
        w_push_nonce = r_dl_base[PIPE_DEPTH-1];
        w_extra      = 5'd0;
        if (r_dl_valid[PIPE_DEPTH-1] && (w_hit16 != 16'd0)) begin
            w_push       = 1'b1;
            w_push_nonce = r_dl_base[PIPE_DEPTH-1] + NONCE_W'(lowest_idx16(w_hit16));
            w_extra      = popcount16(w_hit16) - 5'd1;
        end else begin
            w_push       = 1'b0;
        end
        w_drop_sum = {1'b0, r_dropped} + 17'(w_extra) + 17'(w_push & w_fifo_full & ~w_pop);
        if (w_drop_sum[16]) begin
            w_drop_next = 16'hFFFF;
        end else begin
            w_drop_next = w_drop_sum[15:0];
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Work capture, nonce issue, drain timing and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_core_midstate <= '0;
            r_core_data     <= '0;
            r_core_nonce    <= '0;
            r_core_issue    <= 1'b0;
            r_base          <= '0;
            r_end           <= '0;
            r_more          <= 1'b0;
            r_loop_cnt      <= 6'd0;
            r_drain_cnt     <= 16'd0;
            r_busy          <= 1'b0;
            r_range_done    <= 1'b0;
            r_dropped       <= 16'd0;
        end else begin
            if (w_accept) begin
                r_core_midstate <= i_work_midstate;
                r_core_data     <= i_work_data;
                r_end           <= i_work_nonce_end;
            end
            r_core_issue <= w_issue_now;
            if (w_issue_now) begin
                for (int k = 0; k < NUM_CORES; k++) begin
                    r_core_nonce[k*NONCE_W +: NONCE_W] <= w_issue_base + NONCE_W'(k);
                end
                r_base     <= w_issue_base + NONCE_W'(NUM_CORES);
                r_more     <= ~w_issue_last;
                r_loop_cnt <= 6'd0;
            end else if (r_state == ST_RUN) begin
                r_loop_cnt <= r_loop_cnt + 6'd1;
            end
            if (w_last_seen && !w_accept) begin
                r_drain_cnt <= 16'(PIPE_DEPTH - 1);
            end else if ((r_state == ST_DRAIN) && (r_drain_cnt != 16'd0)) begin
                r_drain_cnt <= r_drain_cnt - 16'd1;
            end
            r_busy       <= (w_next_state != ST_IDLE);
            r_range_done <= w_range_done_nx;
            r_dropped    <= w_drop_next;
        end
    end

    // Delay line pairing each issue with its base; a new load invalidates all stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dl_valid <= '0;
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                r_dl_base[i] <= '0;
            end
        end else begin
            for (int i = PIPE_DEPTH - 1; i > 0; i--) begin
                r_dl_valid[i] <= r_dl_valid[i-1];
                r_dl_base[i]  <= r_dl_base[i-1];
            end
            r_dl_valid[0] <= r_core_issue;
            r_dl_base[0]  <= r_core_nonce[NONCE_W-1:0];
            if (w_accept) begin
                r_dl_valid <= '0;
            end
        end
    end

    gn_fifo #(
        .WIDTH (NONCE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_gn_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (w_push_nonce),
        .i_pop   (w_pop),
        .o_data  (o_gn_nonce),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

endmodule

// File: tb/tb_nonce_dispatch.sv
// Directed bench for nonce_dispatch: one default instance plus one with
// LOOP_LOG2=2 for issue-spacing and mid-run reset checks.
module tb_nonce_dispatch;

    localparam logic [255:0] MID = 256'h635ef71f_a5c31d7e_0b9f2468_13579bdf_2468ace0_fedcba98_76543210_1620437b;
    localparam logic [95:0]  DAT = 96'he5e1081ae9a4374e1e8d8d13;

    logic         clk = 1'b0;
    logic         rst_n, rst2_n;
    logic         work_valid, work_valid2, gn_ready, gn_ready2;
    logic [255:0] midstate;
    logic [95:0]  data;
    logic [31:0]  nstart, nend;
    logic [3:0]   hit, hit2;

    logic         work_ready, core_issue, gn_valid, busy, range_done;
    logic [255:0] core_midstate;
    logic [95:0]  core_data;
    logic [127:0] core_nonce;
    logic [31:0]  gn_nonce;
    logic [15:0]  dropped;

    logic         work_ready2, core_issue2, gn_valid2, busy2, range_done2;
    logic [255:0] core_midstate2;
    logic [95:0]  core_data2;
    logic [127:0] core_nonce2;
    logic [31:0]  gn_nonce2;
    logic [15:0]  dropped2;

    int total = 0;
    int bad   = 0;
    int n;

    always #5 clk = ~clk;

    nonce_dispatch #(.NUM_CORES(4), .LOOP_LOG2(0), .PIPE_DEPTH(8), .FIFO_DEPTH(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .i_work_valid(work_valid), .o_work_ready(work_ready),
        .i_work_midstate(midstate), .i_work_data(data), .i_work_nonce_start(nstart),
        .i_work_nonce_end(nend), .o_core_midstate(core_midstate), .o_core_data(core_data),
        .o_core_nonce(core_nonce), .o_core_issue(core_issue), .i_core_hit(hit),
        .o_gn_valid(gn_valid), .i_gn_ready(gn_ready), .o_gn_nonce(gn_nonce),
        .o_busy(busy), .o_range_done(range_done), .o_dropped_cnt(dropped));

    nonce_dispatch #(.NUM_CORES(4), .LOOP_LOG2(2), .PIPE_DEPTH(8), .FIFO_DEPTH(4)) u_dut2 (
        .clk(clk), .rst_n(rst2_n), .i_work_valid(work_valid2), .o_work_ready(work_ready2),
        .i_work_midstate(midstate), .i_work_data(data), .i_work_nonce_start(nstart),
        .i_work_nonce_end(nend), .o_core_midstate(core_midstate2), .o_core_data(core_data2),
        .o_core_nonce(core_nonce2), .o_core_issue(core_issue2), .i_core_hit(hit2),
        .o_gn_valid(gn_valid2), .i_gn_ready(gn_ready2), .o_gn_nonce(gn_nonce2),
        .o_busy(busy2), .o_range_done(range_done2), .o_dropped_cnt(dropped2));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [31:0] s, input logic [31:0] e);
        nstart = s;
        nend = e;
        work_valid = 1'b1;
        step();
        work_valid = 1'b0;
    endtask

    task automatic load2(input logic [31:0] s, input logic [31:0] e);
        nstart = s;
        nend = e;
        work_valid2 = 1'b1;
        step();
        work_valid2 = 1'b0;
    endtask

    task automatic pop1();
        gn_ready = 1'b1;
        step();
        gn_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; rst2_n = 1'b0;
        work_valid = 1'b0; work_valid2 = 1'b0; gn_ready = 1'b0; gn_ready2 = 1'b0;
        midstate = MID; data = DAT; nstart = 32'd0; nend = 32'd0; hit = 4'd0; hit2 = 4'd0;
        step(); step();
        chk("rst_busy", busy, 1'b0);
        chk("rst_ready", work_ready, 1'b1);
        chk("rst_gn_valid", gn_valid, 1'b0);
        chk("rst_gn_nonce", gn_nonce, 32'd0);
        chk("rst_issue", core_issue, 1'b0);
        chk("rst_core_nonce", core_nonce, 128'd0);
        chk("rst_midstate", core_midstate, 256'd0);
        chk("rst_dropped", dropped, 16'd0);
        chk("rst_range_done", range_done, 1'b0);
        rst_n = 1'b1; rst2_n = 1'b1;
        step();

        // Basic range: 4 issues, hit on core 2 of the first set, drain timing.
        load(32'h195a2c50, 32'h195a2c5f);
        chk("t1_midstate", core_midstate, MID);
        chk("t1_data", core_data, DAT);
        chk("t1_busy", busy, 1'b1);
        chk("t1_core2", core_nonce[95:64], 32'h195a2c52);
        for (int i = 0; i < 4; i++) begin
            chk("t1_issue", core_issue, 1'b1);
            chk("t1_base", core_nonce[31:0], 32'h195a2c50 + 32'(4 * i));
            step();
        end
        chk("t1_issue_stop", core_issue, 1'b0);
        repeat (4) step();
        hit = 4'b0100;
        step();
        hit = 4'b0000;
        chk("t1_gn_valid", gn_valid, 1'b1);
        chk("t1_gn_nonce", gn_nonce, 32'h195a2c52);
        chk("t1_rd_early", range_done, 1'b0);
        step();
        chk("t1_rd_early2", range_done, 1'b0);
        step();
        chk("t1_range_done", range_done, 1'b1);
        chk("t1_busy_drain", busy, 1'b1);
        step();
        chk("t1_busy_low", busy, 1'b0);
        chk("t1_rd_pulse", range_done, 1'b0);
        pop1();
        chk("t1_popped", gn_valid, 1'b0);
        hit = 4'hF;
        step();
        hit = 4'h0;
        step();
        chk("t1_idle_hit", gn_valid, 1'b0);
        chk("t1_idle_drop", dropped, 16'd0);

        // Top of nonce space: two issues, no wrap; multi-bit hit.
        load(32'hFFFFFFF8, 32'hFFFFFFFF);
        chk("t2_issue0", core_issue, 1'b1);
        chk("t2_base0", core_nonce[31:0], 32'hFFFFFFF8);
        step();
        chk("t2_issue1", core_issue, 1'b1);
        chk("t2_base1", core_nonce[31:0], 32'hFFFFFFFC);
        chk("t2_core3", core_nonce[127:96], 32'hFFFFFFFF);
        step();
        chk("t2_no_wrap", core_issue, 1'b0);
        n = 0;
        repeat (6) begin
            step();
            if (core_issue) n++;
        end
        chk("t2_extra_issues", n, 0);
        hit = 4'b1011;
        step();
        hit = 4'b0000;
        chk("t2_gn_nonce", gn_nonce, 32'hFFFFFFF8);
        chk("t2_dropped", dropped, 16'd2);
        chk("t2_range_done", range_done, 1'b1);
        step();
        chk("t2_busy_low", busy, 1'b0);
        pop1();
        chk("t2_popped", gn_valid, 1'b0);

        // FIFO overflow: 5 single hits with gn_ready low.
        load(32'h00000100, 32'h0000011F);
        repeat (8) step();
        hit = 4'b0001;
        repeat (5) step();
        hit = 4'b0000;
        chk("t3_dropped", dropped, 16'd3);
        chk("t3_gn_valid", gn_valid, 1'b1);
        for (int i = 0; i < 4; i++) begin
            chk("t3_fifo_order", gn_nonce, 32'h00000100 + 32'(4 * i));
            pop1();
        end
        chk("t3_fifo_empty", gn_valid, 1'b0);
        repeat (4) step();
        chk("t3_idle", busy, 1'b0);

        // New work during drain: stale hits ignored, no old range_done.
        load(32'h00001000, 32'h00001007);
        step(); step();
        chk("t4_draining", busy, 1'b1);
        step();
        load(32'h00002000, 32'h00002003);
        chk("t4_new_issue", core_issue, 1'b1);
        chk("t4_new_base", core_nonce[31:0], 32'h00002000);
        repeat (4) step();
        hit = 4'b0001;
        step();
        chk("t4_no_old_rd", range_done, 1'b0);
        step();
        hit = 4'b0000;
        chk("t4_stale_hit", gn_valid, 1'b0);
        step(); step();
        chk("t4_new_rd", range_done, 1'b1);
        hit = 4'b0010;
        step();
        hit = 4'b0000;
        chk("t4_gn_nonce", gn_nonce, 32'h00002001);
        chk("t4_dropped", dropped, 16'd3);
        pop1();

        // LOOP_LOG2=2 instance: spacing 4, then reset mid-run.
        load2(32'h00000000, 32'h000000FF);
        chk("t5_issue0", core_issue2, 1'b1);
        step();
        chk("t5_gap", core_issue2, 1'b0);
        repeat (3) step();
        chk("t5_issue1", core_issue2, 1'b1);
        chk("t5_base1", core_nonce2[31:0], 32'h00000004);
        step(); step();
        rst2_n = 1'b0;
        #1;
        chk("t5_rst_busy", busy2, 1'b0);
        chk("t5_rst_issue", core_issue2, 1'b0);
        chk("t5_rst_nonce", core_nonce2, 128'd0);
        chk("t5_rst_mid", core_midstate2, 256'd0);
        chk("t5_rst_gn_valid", gn_valid2, 1'b0);
        chk("t5_rst_rd", range_done2, 1'b0);
        chk("t5_rst_ready", work_ready2, 1'b1);
        step();
        rst2_n = 1'b1;
        step();
        load2(32'h00000040, 32'h000000FF);
        chk("t5_reload_issue", core_issue2, 1'b1);
        chk("t5_reload_base", core_nonce2[31:0], 32'h00000040);
        n = 0;
        repeat (3) begin
            step();
            if (core_issue2) n++;
        end
        chk("t5_reload_gap", n, 0);
        step();
        chk("t5_reload_issue1", core_issue2, 1'b1);
        chk("t5_reload_base1", core_nonce2[31:0], 32'h00000044);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nonce_dispatch.md
NONCE_DISPATCH -- requirements
Module: nonce_dispatch

Interface
REQ-001 Parameter NUM_CORES, default 4, number of hashing cores fed in parallel (power of 2, 1..16).
REQ-002 Parameter LOOP_LOG2, default 0, nonce issue every 2^LOOP_LOG2 cycles (0..5).
REQ-003 Parameter PIPE_DEPTH, default 8, cycles from core_issue to the matching core_hit sample (>=1).
REQ-004 Parameter FIFO_DEPTH, default 4, golden-nonce FIFO entries (power of 2).
REQ-005 Port clk, input, 1, sole clock; all logic on the rising edge.
REQ-006 Port rst_n, input, 1, reset, asynchronous assert, active-low.
REQ-007 Port work_valid/work_ready, in/out, 1 each, work-load handshake; transfer when both high.
REQ-008 Port work_midstate, in, 256; work_data, in, 96; work_nonce_start, in, 32; work_nonce_end, in, 32 (inclusive).
REQ-009 Port core_midstate, out, 256; core_data, out, 96; registered copies of accepted work.
REQ-010 Port core_nonce, out, 32*NUM_CORES, slice k = base + k.
REQ-011 Port core_issue, out, 1, one-cycle strobe marking a new core_nonce set.
REQ-012 Port core_hit, in, NUM_CORES, bit k = core k met target for nonce issued PIPE_DEPTH cycles earlier.
REQ-013 Port gn_valid/gn_ready, out/in, 1 each, gn_nonce, out, 32; golden-nonce output stream.
REQ-014 Port busy, out, 1; range_done, out, 1 (one-cycle pulse); dropped_cnt, out, 16 (saturating).

Function
REQ-015 States IDLE, RUN, DRAIN; work_ready SHALL be high in every state.
REQ-016 Work accept in any state SHALL load core_midstate/core_data, set base = work_nonce_start, clear all in-flight valid tags, enter RUN next cycle.
REQ-017 In RUN, core_issue SHALL pulse on the first RUN cycle and every 2^LOOP_LOG2 cycles after; base advances by NUM_CORES after each issue.
REQ-018 Range end SHALL be computed in 33 bits: issue with base+NUM_CORES-1 >= work_nonce_end is the last; then DRAIN; no wrap past 0xFFFFFFFF.
REQ-019 DRAIN SHALL last PIPE_DEPTH cycles, then pulse range_done and go IDLE; busy = (state != IDLE).
REQ-020 A PIPE_DEPTH-stage delay line SHALL carry {valid, base} per cycle; core_hit is ignored unless the aligned stage is valid.
REQ-021 Valid hit SHALL push base_delayed + k into the FIFO, k = lowest set hit bit; each other set bit increments dropped_cnt.
REQ-022 Push while FIFO full SHALL be discarded and increment dropped_cnt; a push and pop in the same cycle on a full FIFO SHALL both succeed.
REQ-023 gn_valid = FIFO non-empty; gn_nonce = head; pop on gn_valid & gn_ready; FIFO contents survive new work loads.
REQ-024 Hit nonces past work_nonce_end (last partial issue) SHALL still be reported; cores own target checking.
REQ-025 Work accepted during DRAIN SHALL abandon the drain with no range_done pulse.

Reset
REQ-026 rst_n low SHALL force: state IDLE, core_issue 0, core_nonce 0, core_midstate 0, core_data 0, delay line valids 0, FIFO empty, gn_valid 0, gn_nonce 0, busy 0, range_done 0, dropped_cnt 0; work_ready 1.
REQ-027 Reset mid-RUN SHALL lose all in-flight and queued nonces; no range_done.

Structure
REQ-028 Shared package miner_pkg SHALL hold widths MIDSTATE_W=256, DATA_W=96, NONCE_W=32 and the state encoding.
REQ-029 The FIFO SHALL be sub-module gn_fifo (parametrised width/depth, full/empty, simultaneous push/pop).

Verification
REQ-030 NUM_CORES=4, LOOP_LOG2=0, start 0x195a2c50, end 0x195a2c5f, midstate 0x635ef71f...1620437b, data 0xe5e1081ae9a4374e1e8d8d13 -> 4 issues, core_nonce[2] = 0x195a2c52 on first; core_hit=4'b0100 PIPE_DEPTH cycles later -> gn_nonce 0x195a2c52.
REQ-031 Same load -> range_done exactly PIPE_DEPTH cycles after the 4th issue; busy low the following cycle.
REQ-032 start 0xFFFFFFF8, end 0xFFFFFFFF -> exactly 2 issues (bases 0xFFFFFFF8, 0xFFFFFFFC), no wrap to 0.
REQ-033 core_hit=4'b1011 in one cycle -> gn_nonce base+0, dropped_cnt +2; gn_ready low with 5 single hits, FIFO_DEPTH=4 -> 4 queued, dropped_cnt +1.
REQ-034 New work mid-RUN with hit pending in the delay line -> stale hit ignored, base restarts at new start, no range_done for old range.
REQ-035 rst_n low mid-RUN, LOOP_LOG2=2 -> all outputs at reset values; after release, issue spacing 4 cycles on next load.
